// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, counter-based debounce FSM,
// registered press/release/long-press strobes and a wrapping press counter.
module btn_debounce #(
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 50_000_000
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       btn_in,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic [7:0] press_count
);

   localparam logic [31:0] DebLast  = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] LongLast = 32'(LONG_CYCLES - 1);
   localparam logic [31:0] LongFire = 32'(LONG_CYCLES - 2);

   typedef enum logic [1:0] {
      StIdle,
      StPressChk,
      StHeld,
      StRelChk
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  sync_q;
   logic [31:0] dcnt_q, dcnt_d;
   logic [31:0] hcnt_q, hcnt_d;
   logic        long_done_q, long_done_d;
   logic        level_d, press_d, release_d, long_d;
   logic [7:0]  count_d;
   logic        act;

   // Synchroniser resets to the released pin level so reset never looks like a press.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {2{ACTIVE_LOW}};
      end else begin
         sync_q <= {sync_q[0], btn_in};
      end
   end

   assign act = sync_q[1] ^ ACTIVE_LOW;

   always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      hcnt_d      = hcnt_q;
      long_done_d = long_done_q;
      level_d     = btn_level;
      count_d     = press_count;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;

      // Long press fires on the edge that brings hcnt to its saturation value.
      if (state_q == StHeld || state_q == StRelChk) begin
         if (hcnt_q != LongLast) begin
            hcnt_d = hcnt_q + 32'd1;
         end
         if (hcnt_q == LongFire && !long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (act) begin
               state_d = StPressChk;
               dcnt_d  = 32'd0;
            end
         end
         StPressChk: begin
            if (!act) begin
               state_d = StIdle;
            end else if (dcnt_q == DebLast) begin
               state_d     = StHeld;
               level_d     = 1'b1;
               press_d     = 1'b1;
               count_d     = press_count + 8'd1;
               hcnt_d      = 32'd0;
               long_done_d = 1'b0;
            end else begin
               dcnt_d = dcnt_q + 32'd1;
            end
         end
         StHeld: begin
            if (!act) begin
               state_d = StRelChk;
               dcnt_d  = 32'd0;
            end
         end
         StRelChk: begin
            if (act) begin
               state_d = StHeld;
            end else if (dcnt_q == DebLast) begin
               state_d     = StIdle;
               level_d     = 1'b0;
               release_d   = 1'b1;
               hcnt_d      = 32'd0;
               long_done_d = 1'b0;
            end else begin
               dcnt_d = dcnt_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         dcnt_q        <= 32'd0;
         hcnt_q        <= 32'd0;
         long_done_q   <= 1'b0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         press_count   <= 8'd0;
      end else begin
         state_q       <= state_d;
         dcnt_q        <= dcnt_d;
         hcnt_q        <= hcnt_d;
         long_done_q   <= long_done_d;
         btn_level     <= level_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
         long_pulse    <= long_d;
         press_count   <= count_d;
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: a run-length reference model queues expected
// strobes; an independent monitor pops and compares whenever the DUT strobes.
module tb_btn_debounce;

   localparam int D = 8;
   localparam int L = 40;

   logic       sysclk = 1'b0;
   logic       rst_n;
   logic       btn_in;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic [7:0] press_count;

   btn_debounce #(
      .ACTIVE_LOW      (1'b1),
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L)
   ) dut (
      .sysclk        (sysclk),
      .rst_n         (rst_n),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .press_count   (press_count)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      int         cyc;
      bit         p;
      bit         r;
      bit         l;
      logic [7:0] cnt;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  cyc      = 0;

   // Reference model: pin history, accepted level, run of disagreeing samples, hold age.
   bit         m_s1, m_s2, m_level;
   int         m_run, m_age;
   logic [7:0] m_count;
   int         m_np = 0, m_nr = 0, m_nl = 0;

   // Tallies observed from the DUT
   int seen_p = 0, seen_r = 0, seen_l = 0;
   int last_p_cyc = 0, last_l_cyc = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_s1    = 1'b1;
      m_s2    = 1'b1;
      m_level = 1'b0;
      m_run   = 0;
      m_age   = 0;
      m_count = 8'd0;
   endfunction

   function automatic void model_edge(input bit b);
      bit  act;
      ev_t e;
      act   = !m_s2;  // pin low means pressed, seen two edges late
      m_s2  = m_s1;
      m_s1  = b;
      e.cyc = cyc;
      e.p   = 1'b0;
      e.r   = 1'b0;
      e.l   = 1'b0;
      if (m_level) begin
         if (m_age < L) m_age++;
         if (m_age == L - 1) e.l = 1'b1;
      end
      m_run = (act != m_level) ? m_run + 1 : 0;
      if (m_run == D + 1) begin
         m_run   = 0;
         m_level = !m_level;
         if (m_level) begin
            e.p = 1'b1;
            m_count++;
            m_age = 0;
         end else begin
            e.r = 1'b1;
         end
      end
      e.cnt = m_count;
      if (e.p) m_np++;
      if (e.r) m_nr++;
      if (e.l) m_nl++;
      if (e.p || e.r || e.l) exp_q.push_back(e);
   endfunction

   task automatic tick(input bit b, input bit r);
      btn_in = b;
      rst_n  = r;
      if (!r) model_reset();
      @(posedge sysclk);
      cyc++;
      if (r) model_edge(b);
      #2;
   endtask

   task automatic hold(input bit b, input int n);
      for (int i = 0; i < n; i++) tick(b, 1'b1);
   endtask

   // Monitor
   initial begin
      ev_t e;
      forever begin
         @(negedge sysclk);
         check("btn_level", int'(btn_level), int'(m_level));
         check("press_count", int'(press_count), int'(m_count));
         if (press_pulse || release_pulse || long_pulse) begin
            if (press_pulse) begin seen_p++; last_p_cyc = cyc; end
            if (release_pulse) seen_r++;
            if (long_pulse) begin seen_l++; last_l_cyc = cyc; end
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", int'({press_pulse, release_pulse, long_pulse}), 0);
            end else begin
               e = exp_q.pop_front();
               check("pulse_cycle", cyc, e.cyc);
               check("press_pulse", int'(press_pulse), int'(e.p));
               check("release_pulse", int'(release_pulse), int'(e.r));
               check("long_pulse", int'(long_pulse), int'(e.l));
               check("count_at_pulse", int'(press_count), int'(e.cnt));
            end
         end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("missed_pulse", 0, int'({e.p, e.r, e.l}));
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0, p0, r0, l0;
      model_reset();
      rst_n  = 1'b1;
      btn_in = 1'b1;
      #1;
      repeat (3) tick(1'b1, 1'b0);

      // Clean press
      t0 = cyc + 1;
      hold(1'b0, 30);
      check("clean_press_latency", last_p_cyc - t0, 10);
      hold(1'b1, 20);
      check("clean_press_count", int'(press_count), 1);
      check("clean_no_long", seen_l, 0);
      check("clean_release_seen", seen_r, 1);

      // Bounce rejection
      p0 = seen_p;
      hold(1'b0, 5); hold(1'b1, 3); hold(1'b0, 4); hold(1'b1, 20);
      check("bounce_no_press", seen_p - p0, 0);
      check("bounce_count", int'(press_count), 1);

      // Press with bounce
      p0 = seen_p;
      t0 = cyc + 1;
      hold(1'b0, 3); hold(1'b1, 1); hold(1'b0, 20);
      check("bounce_press_once", seen_p - p0, 1);
      check("bounce_press_latency", last_p_cyc - t0, 14);
      hold(1'b1, 20);

      // Long press with release glitch at cycle 70
      r0 = seen_r; l0 = seen_l;
      t0 = cyc + 1;
      hold(1'b0, 70); hold(1'b1, 3); hold(1'b0, 27);
      check("long_latency", last_l_cyc - t0, 49);
      check("long_once", seen_l - l0, 1);
      check("glitch_no_release", seen_r - r0, 0);
      hold(1'b1, 20);

      // Counter wrap from a fresh reset
      repeat (3) tick(1'b1, 1'b0);
      p0 = seen_p; r0 = seen_r;
      repeat (257) begin
         hold(1'b0, 12);
         hold(1'b1, 12);
      end
      check("wrap_count", int'(press_count), 1);
      check("wrap_press_strobes", seen_p - p0, 257);
      check("wrap_release_strobes", seen_r - r0, 257);

      // Reset mid-press
      repeat (3) tick(1'b1, 1'b0);
      hold(1'b0, 20);
      repeat (5) tick(1'b0, 1'b0);
      t0 = cyc + 1;
      hold(1'b0, 20);
      check("reset_refire_latency", last_p_cyc - t0, 10);
      check("reset_refire_count", int'(press_count), 1);
      hold(1'b1, 20);

      // Randomised segments, occasional reset
      repeat (80) begin
         bit b;
         int n;
         b = 1'($urandom_range(0, 1));
         n = ($urandom_range(0, 6) == 0) ? int'($urandom_range(30, 60))
                                        : int'($urandom_range(1, 12));
         if ($urandom_range(0, 30) == 0) begin
            tick(b, 1'b0);
            tick(b, 1'b0);
         end else begin
            hold(b, n);
         end
      end

      hold(1'b1, 20);
      check("queue_drained", exp_q.size(), 0);
      check("total_press", seen_p, m_np);
      check("total_release", seen_r, m_nr);
      check("total_long", seen_l, m_nl);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
